alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, ports named clk and reset.
REQ-002 The ports SHALL be, one per line, name direction width meaning:
  clk  in  1  rising-edge clock
  reset  in  1  synchronous active-high reset
  start  in  1  command request, sampled only in IDLE
  ld  in  1  1 = load immediate command, 0 = ALU command
  op  in  4  ALU opcode forwarded to the external ALU
  dst  in  3  destination register index
  src_r  in  3  register index driven on alu_r
  src_s  in  3  register index driven on alu_s
  imm  in  16  immediate value for ld commands
  alu_r  out  16  registered R operand to the external ALU
  alu_s  out  16  registered S operand to the external ALU
  alu_op  out  4  registered opcode to the external ALU
  alu_y  in  16  ALU result (combinational from alu_r/alu_s/alu_op)
  alu_n, alu_z, alu_c  in  1 each  ALU status flags
  busy  out  1  high when state != IDLE
  done  out  1  one-cycle completion pulse
  result  out  16  last value written to the register file
  flag_n, flag_z, flag_c  out  1 each  latched status flags

Function
REQ-003 The block SHALL hold eight 16-bit registers r0..r7, all writable.
REQ-004 The FSM SHALL have states IDLE, FETCH, EXEC and LOAD.
REQ-005 In IDLE with start=1 at edge E0, the block SHALL capture ld, op, dst, src_r, src_s and imm, then go to LOAD if ld=1, else to FETCH.
REQ-006 FETCH at edge E1: alu_r <= r[src_r], alu_s <= r[src_s], alu_op <= op; then go to EXEC.
REQ-007 EXEC at edge E2 SHALL perform, then return to IDLE:
  - r[dst] <= alu_y and result <= alu_y
  - flag_n/flag_z/flag_c <= alu_n/alu_z/alu_c
  - done <= 1
REQ-008 ALU command latency SHALL be exactly 3 cycles: done high in the cycle after E2.
REQ-009 LOAD at edge E1 SHALL perform r[dst] <= imm, result <= imm and done <= 1, leave flags unchanged, and return to IDLE; latency is 2 cycles.
REQ-010 done SHALL be high for exactly one cycle per accepted command and low otherwise.
REQ-011 start SHALL be ignored while busy=1; no queuing.
REQ-012 A start in the same cycle as done (state IDLE) SHALL be accepted, allowing back-to-back commands.
REQ-013 Each write-back SHALL complete before the next FETCH, so a command reading the previous dst sees the new value.
REQ-014 Opcodes 1101-1111 SHALL be forwarded unchanged; the block does no opcode decoding.
REQ-015 Operands captured at E0 SHALL NOT change while busy, regardless of input changes.

Reset
REQ-016 On reset=1 at a clock edge, the block SHALL set:
  - state = IDLE
  - r0..r7 = 0x0000, result = 0x0000
  - alu_r = alu_s = 0x0000, alu_op = 4'b0000
  - flags = 0, done = 0, busy = 0
REQ-017 Reset SHALL override start and any state; a command in flight is aborted with no write-back and no done.

Configuration
REQ-018 Macro ALU_SEQ_DBG_READ_EN: when defined, the block SHALL add input dbg_addr[2:0] and output dbg_data[16] = r[dbg_addr], combinational and reflecting a write from the cycle after the write edge.
REQ-019 When ALU_SEQ_DBG_READ_EN is undefined, those ports SHALL be absent and all other behaviour identical.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  - ld r1=0x0005, ld r2=0x0003, then op=0100 dst=3 src_r=1 src_s=2 -> r3=result=0x0008; N=0 Z=0 C=0; done 3 cycles after start.
  - op=0101 dst=5 src_r=1 src_s=1 with r1=0x0005 -> result=0x0000, Z=1, N=0.
  - ld r4=0xFFFF, then op=0010 dst=4 src_s=4 -> r4=0x0000, Z=1, C=1; the ld leaves flags unchanged.
  - start held high for 6 cycles from IDLE with an ALU command -> exactly two done pulses (cycles 3 and 6), second command accepted in the done cycle.
  - reset asserted during EXEC -> no done, busy=0 next cycle, all registers and flags 0.
  - with ALU_SEQ_DBG_READ_EN, ld r7=0xA5A5 then dbg_addr=7 -> dbg_data=0xA5A5 in the cycle after done.

Source files
------------

// File: rtl/alu_seq.sv
// Sequencer driving an external combinational ALU from an 8 x 16-bit register file.
// Optional `ALU_SEQ_DBG_READ_EN adds a combinational register read port (dbg_addr/dbg_data).
module alu_seq (
`ifdef ALU_SEQ_DBG_READ_EN
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
`endif
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld,
  input  logic [3:0]  op,
  input  logic [2:0]  dst,
  input  logic [2:0]  src_r,
  input  logic [2:0]  src_s,
  input  logic [15:0] imm,
  output logic [15:0] alu_r,
  output logic [15:0] alu_s,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_y,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_c,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_c
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, LOAD} state_t;

  // Handshake: start is sampled only while IDLE (busy=0); done pulses for one cycle per
  // accepted command, and a start seen alongside done is accepted because state is IDLE then.
  state_t      state;
  logic [15:0] regs [8];
  logic [3:0]  op_q;
  logic [2:0]  dst_q;
  logic [2:0]  src_r_q;
  logic [2:0]  src_s_q;
  logic [15:0] imm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
      op_q    <= 4'b0000;
      dst_q   <= 3'd0;
      src_r_q <= 3'd0;
      src_s_q <= 3'd0;
      imm_q   <= 16'h0000;
      alu_r   <= 16'h0000;
      alu_s   <= 16'h0000;
      alu_op  <= 4'b0000;
      result  <= 16'h0000;
      flag_n  <= 1'b0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            dst_q   <= dst;
            src_r_q <= src_r;
            src_s_q <= src_s;
            imm_q   <= imm;
            state   <= ld ? LOAD : FETCH;
          end
        end
        FETCH: begin
          alu_r  <= regs[src_r_q];
          alu_s  <= regs[src_s_q];
          alu_op <= op_q;
          state  <= EXEC;
        end
        EXEC: begin
          regs[dst_q] <= alu_y;
          result      <= alu_y;
          flag_n      <= alu_n;
          flag_z      <= alu_z;
          flag_c      <= alu_c;
          done        <= 1'b1;
          state       <= IDLE;
        end
        LOAD: begin
          regs[dst_q] <= imm_q;
          result      <= imm_q;
          done        <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef ALU_SEQ_DBG_READ_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: models the external ALU, keeps a reference register file,
// and scoreboards result/flags on every done pulse.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, start, ld;
  logic [3:0]  op;
  logic [2:0]  dst, src_r, src_s;
  logic [15:0] imm;
  logic [15:0] alu_r, alu_s, alu_y;
  logic [3:0]  alu_op;
  logic        alu_n, alu_z, alu_c;
  logic        busy, done, flag_n, flag_z, flag_c;
  logic [15:0] result;
`ifdef ALU_SEQ_DBG_READ_EN
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
`endif

  int checks = 0;
  int failures = 0;
  logic [18:0] exp_q[$];
  logic [15:0] m_reg [8];
  logic        m_n, m_z, m_c;

  alu_seq dut (
`ifdef ALU_SEQ_DBG_READ_EN
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
`endif
    .clk(clk), .reset(reset), .start(start), .ld(ld), .op(op), .dst(dst),
    .src_r(src_r), .src_s(src_s), .imm(imm), .alu_r(alu_r), .alu_s(alu_s),
    .alu_op(alu_op), .alu_y(alu_y), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c),
    .busy(busy), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c)
  );

  // Clock
  always #5 clk = ~clk;

  // External ALU: {carry, y}; sub reports borrow in carry
  function automatic logic [16:0] alu_fn(logic [3:0] o, logic [15:0] r, logic [15:0] s);
    case (o)
      4'b0010: return {1'b0, s} + 17'd1;
      4'b0100: return {1'b0, r} + {1'b0, s};
      4'b0101: return {1'b0, r} - {1'b0, s};
      4'b0110: return {1'b0, r & s};
      4'b0111: return {1'b0, r | s};
      4'b1000: return {1'b0, r ^ s};
      4'b1101: return {1'b0, ~r};
      default: return {1'b0, r};
    endcase
  endfunction

  assign {alu_c, alu_y} = alu_fn(alu_op, alu_r, alu_s);
  assign alu_n = alu_y[15];
  assign alu_z = (alu_y == 16'h0000);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
    m_n = 1'b0; m_z = 1'b0; m_c = 1'b0;
  endtask

  // Updates the reference model and pushes the expected {result, n, z, c}
  task automatic model_push(input logic l, input logic [3:0] o, input logic [2:0] d,
                            input logic [2:0] sr, input logic [2:0] ss, input logic [15:0] im);
    logic [16:0] v;
    logic [15:0] y;
    if (l) begin
      y = im;
    end else begin
      v = alu_fn(o, m_reg[sr], m_reg[ss]);
      y = v[15:0];
      m_c = v[16];
      m_n = y[15];
      m_z = (y == 16'h0000);
    end
    m_reg[d] = y;
    exp_q.push_back({y, m_n, m_z, m_c});
  endtask

  task automatic drive(input logic l, input logic [3:0] o, input logic [2:0] d,
                       input logic [2:0] sr, input logic [2:0] ss, input logic [15:0] im);
    ld = l; op = o; dst = d; src_r = sr; src_s = ss; imm = im;
  endtask

  // One command from IDLE; inputs are scrambled (with start held) while busy
  task automatic run_cmd(input logic l, input logic [3:0] o, input logic [2:0] d,
                         input logic [2:0] sr, input logic [2:0] ss, input logic [15:0] im);
    int cycles;
    logic [15:0] er, es;
    er = m_reg[sr];
    es = m_reg[ss];
    model_push(l, o, d, sr, ss, im);
    start = 1'b1;
    drive(l, o, d, sr, ss, im);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (!done) begin
        chk("busy_in_flight", busy, 1);
        if (!l && cycles == 2) begin
          chk("alu_op_fwd", alu_op, o);
          chk("alu_r_operand", alu_r, er);
          chk("alu_s_operand", alu_s, es);
        end
        start = 1'b1;
        drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));
      end
    end while (!done && cycles < 8);
    start = 1'b0;
    chk("latency", cycles, l ? 2 : 3);
  endtask

  // Scoreboard
  always @(negedge clk) begin
    logic [18:0] e;
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", result, e[18:3]);
        chk("sb_flags", {flag_n, flag_z, flag_c}, e[2:0]);
      end
    end
  end

  initial begin
    logic [7:0] mask;
    reset = 1'b1;
    start = 1'b0;
    drive(0, 4'b0000, 0, 0, 0, 16'h0000);
`ifdef ALU_SEQ_DBG_READ_EN
    dbg_addr = 3'd0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {flag_n, flag_z, flag_c}, 3'b000);
    chk("rst_alu_r", alu_r, 16'h0000);
    chk("rst_alu_s", alu_s, 16'h0000);
    chk("rst_alu_op", alu_op, 4'b0000);
    reset = 1'b0;
    @(negedge clk);

    // Add of two loaded registers
    run_cmd(1, 4'b0000, 1, 0, 0, 16'h0005);
    run_cmd(1, 4'b0000, 2, 0, 0, 16'h0003);
    run_cmd(0, 4'b0100, 3, 1, 2, 16'h0000);
    chk("add_result", result, 16'h0008);
    chk("add_flags", {flag_n, flag_z, flag_c}, 3'b000);

    // Subtract to zero
    run_cmd(0, 4'b0101, 5, 1, 1, 16'h0000);
    chk("sub_result", result, 16'h0000);
    chk("sub_nz", {flag_n, flag_z}, 2'b01);

    // Load leaves flags alone, then increment wraps with carry
    run_cmd(1, 4'b0000, 4, 0, 0, 16'hFFFF);
    chk("ld_keeps_flags", {flag_n, flag_z, flag_c}, 3'b010);
    run_cmd(0, 4'b0010, 4, 0, 4, 16'h0000);
    chk("inc_result", result, 16'h0000);
    chk("inc_zc", {flag_z, flag_c}, 2'b11);

    // Read-after-write and unused opcodes passed straight through
    run_cmd(0, 4'b0100, 0, 4, 3, 16'h0000);
    run_cmd(0, 4'b1101, 6, 3, 0, 16'h0000);
    run_cmd(0, 4'b1110, 7, 3, 0, 16'h0000);
    run_cmd(0, 4'b1111, 7, 5, 2, 16'h0000);

    for (int i = 0; i < 8; i++)
      run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 16'($urandom));

    // start held for six cycles: second command accepted in the first done cycle
    model_push(0, 4'b0100, 6, 3, 1, 16'h0000);
    model_push(0, 4'b0100, 6, 3, 1, 16'h0000);
    start = 1'b1;
    drive(0, 4'b0100, 6, 3, 1, 16'h0000);
    mask = 8'h00;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      mask[i] = done;
      if (i == 6) start = 1'b0;
    end
    chk("b2b_done_cycles", mask, 8'b0100_1000);

    // Reset while in EXEC aborts the command
    start = 1'b1;
    drive(0, 4'b0100, 2, 1, 2, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", result, 16'h0000);
    chk("abort_flags", {flag_n, flag_z, flag_c}, 3'b000);
    chk("abort_alu_r", alu_r, 16'h0000);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    chk("abort_no_done", done, 0);
    run_cmd(0, 4'b0111, 0, 1, 6, 16'h0000);
    run_cmd(0, 4'b0111, 0, 3, 5, 16'h0000);

`ifdef ALU_SEQ_DBG_READ_EN
    dbg_addr = 3'd7;
    run_cmd(1, 4'b0000, 7, 0, 0, 16'hA5A5);
    @(negedge clk);
    chk("dbg_read", dbg_data, 16'hA5A5);
    dbg_addr = 3'd4;
    @(negedge clk);
    chk("dbg_read_r4", dbg_data, m_reg[4]);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
